// File: rtl/tq_pkg.sv
// Shared types and helpers for the transform-quantise control blocks.
// Holds transize encodings, the stage1 controller state enum and issue-count lookup.
package tq_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    TS_4  = 2'd0,
    TS_8  = 2'd1,
    TS_16 = 2'd2,
    TS_32 = 2'd3
  } transize_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Row issues per block: N*N/32 lanes, never fewer than one.
  function automatic logic [CNT_W-1:0] issue_n(input logic [1:0] transize);
    logic [CNT_W-1:0] n;
    case (transize)
      TS_4:    n = 6'd1;
      TS_8:    n = 6'd2;
      TS_16:   n = 6'd8;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tq_valid_delay.sv
// Fixed-depth valid pipeline matching the buffer read latency.
// DEPTH=0 is a straight wire.
module tq_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/stage1_ctrl.sv
// Sequences one transform block through stage1: latches config, issues row reads,
// counts stage1 returns and pulses done on the last one.
module stage1_ctrl
  import tq_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        transize_in,
  input  logic              inverse_in,
  input  logic              stall,
  output logic              ready,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              s1_valid,
  output logic              s1_inverse,
  output logic [1:0]        s1_transize,
  input  logic              s1_ovalid,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshake: a block is accepted on any cycle with start=1 and ready=1;
  // start is a single-cycle request and is ignored whenever ready=0.

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] issue_cnt;
  logic [CNT_W-1:0]  ret_cnt, ret_cnt_nxt, issue_total;
  logic [1:0]        ts_q;
  logic              inv_q;
  logic              accept, last_issue, ret_ok, ret_bad;

  assign issue_total = issue_n(ts_q);
  assign accept      = (state == IDLE) && start;
  assign last_issue  = (CNT_W'(issue_cnt) == (issue_total - CNT_W'(1)));

  // A return is legal only inside a block and only while returns are outstanding.
  assign ret_ok      = s1_ovalid && (state != IDLE) && (ret_cnt != issue_total);
  assign ret_bad     = s1_ovalid && !ret_ok;
  assign ret_cnt_nxt = ret_cnt + CNT_W'(ret_ok);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!stall) begin
          rd_en = 1'b1;
          if (last_issue) state_nxt = (ret_cnt_nxt == issue_total) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (ret_cnt_nxt == issue_total) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      ts_q      <= '0;
      inv_q     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ts_q      <= transize_in;
        inv_q     <= inverse_in;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        // Clear the row index after the final issue so rd_addr rests at 0.
        if (rd_en) issue_cnt <= last_issue ? '0 : issue_cnt + 1'b1;
        ret_cnt <= ret_cnt_nxt;
      end
      if (ret_bad) err <= 1'b1;
    end
  end

  tq_valid_delay #(.DEPTH(RD_LAT)) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en),
    .dout (s1_valid)
  );

  assign ready       = (state == IDLE);
  assign busy        = ~ready;
  assign done        = (state == DONE);
  assign rd_addr     = issue_cnt;
  assign s1_inverse  = inv_q;
  assign s1_transize = ts_q;
  assign state_dbg   = state;

endmodule
